// File: rtl/arb_pkg.sv
// Shared definitions for the bus arbiter and the bus-ownership controller.
package arb_pkg;

  localparam int N_MASTERS = 4;
  localparam int IDX_W     = $clog2(N_MASTERS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [N_MASTERS-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < N_MASTERS; i++) cnt += int'(v[i]);
    return (cnt == 1);
  endfunction

  // Lowest set bit wins, matching the arbiter's encoder.
  function automatic logic [IDX_W-1:0] onehot_index(input logic [N_MASTERS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Up-counter that reloads to zero, with a terminal-count flag against a limit.
module hold_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == limit);

endmodule

// File: rtl/bus_grant_ctrl.sv
// Bus-ownership controller: holds the arbiter's grant, forces release after
// MAX_HOLD cycles, enforces a turnaround gap and locks out timed-out masters.
module bus_grant_ctrl
  import arb_pkg::*;
#(
  parameter int MAX_HOLD   = 16,
  parameter int TURNAROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] BR,
  output logic [N_MASTERS-1:0] REQ_OUT,
  input  logic [N_MASTERS-1:0] BG,
  output logic [N_MASTERS-1:0] GNT,
  output logic [IDX_W-1:0]     OWNER,
  output logic                 BUSY,
  output logic                 TIMEOUT
);

  localparam int              HOLD_W   = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);
  localparam logic [1:0]      TURN_LIM = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;

  state_t               state;
  logic [N_MASTERS-1:0] penalty;
  logic                 owner_req;
  logic                 hold_inc;
  logic                 hold_tc;
  logic                 turn_inc;
  logic                 turn_tc;

  assign REQ_OUT   = BR & ~penalty;
  assign owner_req = BR[OWNER];

  // The hold counter only advances while the grant is kept, so it is zero on
  // entry to GRANT and never runs past the limit.
  assign hold_inc = (state == GRANT) && owner_req && !hold_tc;
  assign turn_inc = (state == TURN);

  hold_timer #(.WIDTH(HOLD_W)) u_hold_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!hold_inc),
    .inc   (hold_inc),
    .limit (HOLD_LIM),
    .tc    (hold_tc)
  );

  hold_timer #(.WIDTH(2)) u_turn_timer (
    .clk   (clk),
    .rst   (rst),
    .clear (!turn_inc),
    .inc   (turn_inc),
    .limit (TURN_LIM),
    .tc    (turn_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      GNT     <= '0;
      OWNER   <= '0;
      BUSY    <= 1'b0;
      TIMEOUT <= 1'b0;
      penalty <= '0;
    end else begin
      TIMEOUT <= 1'b0;
      penalty <= penalty & BR;
      case (state)
        IDLE: begin
          if (is_onehot(BG)) begin
            GNT   <= BG;
            OWNER <= onehot_index(BG);
            BUSY  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || hold_tc) begin
            GNT   <= '0;
            OWNER <= '0;
            BUSY  <= 1'b0;
            state <= (TURNAROUND == 0) ? IDLE : TURN;
            // Releasing on the limit cycle is a normal release, not a timeout.
            if (owner_req) begin
              TIMEOUT <= 1'b1;
              penalty <= (penalty & BR) | (N_MASTERS'(1) << OWNER);
            end
          end
        end
        TURN: begin
          if (turn_tc) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Scoreboard bench for bus_grant_ctrl with a fixed-priority arbiter model.
module tb_bus_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic [3:0] force_val = 4'b0000;

  logic [3:0] br_a = '0, br_b = '0;
  logic [3:0] req_a, req_b, bg_a, bg_b, gnt_a, gnt_b;
  logic [1:0] owner_a, owner_b;
  logic       busy_a, busy_b, to_a, to_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       busy;
    logic       to;
    logic [3:0] req;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  function automatic logic [3:0] arb(input logic [3:0] r);
    logic [3:0] g;
    g = 4'b0000;
    for (int i = 3; i >= 0; i--) if (r[i]) g = 4'b0001 << i;
    return g;
  endfunction

  always_comb begin
    bg_a = arb(req_a);
    bg_b = arb(req_b);
    if (force_val != 4'b0000) begin
      if (sel) bg_b = force_val;
      else     bg_a = force_val;
    end
  end

  bus_grant_ctrl #(.MAX_HOLD(16), .TURNAROUND(1)) dut_a (
    .clk(clk), .rst(rst), .BR(br_a), .REQ_OUT(req_a), .BG(bg_a),
    .GNT(gnt_a), .OWNER(owner_a), .BUSY(busy_a), .TIMEOUT(to_a)
  );

  bus_grant_ctrl #(.MAX_HOLD(4), .TURNAROUND(0)) dut_b (
    .clk(clk), .rst(rst), .BR(br_b), .REQ_OUT(req_b), .BG(bg_b),
    .GNT(gnt_b), .OWNER(owner_b), .BUSY(busy_b), .TIMEOUT(to_b)
  );

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic cyc(input logic [3:0] br, input logic r, input logic [3:0] eg,
                     input logic [1:0] eo, input logic eb, input logic et,
                     input logic [3:0] er, input logic [3:0] fb = 4'b0000);
    exp_t e;
    @(negedge clk);
    rst       = r;
    force_val = fb;
    if (sel) begin br_b = br; br_a = 4'b0000; end
    else     begin br_a = br; br_b = 4'b0000; end
    e.sel = sel; e.gnt = eg; e.owner = eo; e.busy = eb; e.to = et; e.req = er;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.sel) begin
          chk("b_gnt", gnt_b, e.gnt);
          chk("b_owner", {2'b00, owner_b}, {2'b00, e.owner});
          chk("b_busy", {3'b000, busy_b}, {3'b000, e.busy});
          chk("b_timeout", {3'b000, to_b}, {3'b000, e.to});
          chk("b_req_out", req_b, e.req);
        end else begin
          chk("a_gnt", gnt_a, e.gnt);
          chk("a_owner", {2'b00, owner_a}, {2'b00, e.owner});
          chk("a_busy", {3'b000, busy_a}, {3'b000, e.busy});
          chk("a_timeout", {3'b000, to_a}, {3'b000, e.to});
          chk("a_req_out", req_a, e.req);
        end
      end
    end
  end

  initial begin : stimulus
    int waited;
    // Reset
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 1, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);

    // Basic grant to master 2, release and one turnaround cycle
    cyc(4'b0100, 0, 4'b0100, 2, 1, 0, 4'b0100);
    cyc(4'b0100, 0, 4'b0100, 2, 1, 0, 4'b0100);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);

    // Master 0 holds past the limit: 16 grant cycles then forced release
    for (int i = 0; i < 16; i++) cyc(4'b1001, 0, 4'b0001, 0, 1, 0, 4'b1001);
    cyc(4'b1001, 0, 4'b0000, 0, 0, 1, 4'b1000);
    cyc(4'b1001, 0, 4'b0000, 0, 0, 0, 4'b1000);
    cyc(4'b1001, 0, 4'b1000, 3, 1, 0, 4'b1000);
    cyc(4'b1000, 0, 4'b1000, 3, 1, 0, 4'b1000);
    cyc(4'b1001, 0, 4'b1000, 3, 1, 0, 4'b1001);
    cyc(4'b0001, 0, 4'b0000, 0, 0, 0, 4'b0001);
    cyc(4'b0001, 0, 4'b0000, 0, 0, 0, 4'b0001);
    cyc(4'b0001, 0, 4'b0001, 0, 1, 0, 4'b0001);

    // Owner drops exactly on the limit cycle: normal release
    for (int i = 0; i < 15; i++) cyc(4'b0001, 0, 4'b0001, 0, 1, 0, 4'b0001);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0001, 0, 4'b0000, 0, 0, 0, 4'b0001);
    cyc(4'b0001, 0, 4'b0001, 0, 1, 0, 4'b0001);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);

    // Higher-priority requests arrive mid-grant: no preemption
    cyc(4'b0100, 0, 4'b0100, 2, 1, 0, 4'b0100);
    cyc(4'b0100, 0, 4'b0100, 2, 1, 0, 4'b0100);
    cyc(4'b0101, 0, 4'b0100, 2, 1, 0, 4'b0101);
    cyc(4'b0110, 0, 4'b0100, 2, 1, 0, 4'b0110);
    cyc(4'b0010, 0, 4'b0000, 0, 0, 0, 4'b0010);
    cyc(4'b0010, 0, 4'b0000, 0, 0, 0, 4'b0010);
    cyc(4'b0010, 0, 4'b0010, 1, 1, 0, 4'b0010);

    // Master 1 times out, master 2 takes over, then reset mid-grant
    for (int i = 0; i < 15; i++) cyc(4'b0010, 0, 4'b0010, 1, 1, 0, 4'b0010);
    cyc(4'b0110, 0, 4'b0000, 0, 0, 1, 4'b0100);
    cyc(4'b0110, 0, 4'b0000, 0, 0, 0, 4'b0100);
    cyc(4'b0110, 0, 4'b0100, 2, 1, 0, 4'b0100);
    cyc(4'b0110, 1, 4'b0000, 0, 0, 0, 4'b0110);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);

    // Second instance: MAX_HOLD=4, TURNAROUND=0
    sel = 1'b1;
    cyc(4'b0011, 0, 4'b0001, 0, 1, 0, 4'b0011);
    cyc(4'b0010, 0, 4'b0000, 0, 0, 0, 4'b0010);
    cyc(4'b0010, 0, 4'b0010, 1, 1, 0, 4'b0010);
    for (int i = 0; i < 3; i++) cyc(4'b0010, 0, 4'b0010, 1, 1, 0, 4'b0010);
    cyc(4'b0010, 0, 4'b0000, 0, 0, 1, 4'b0000);
    cyc(4'b0010, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);
    cyc(4'b0010, 0, 4'b0010, 1, 1, 0, 4'b0010);
    cyc(4'b0000, 0, 4'b0000, 0, 0, 0, 4'b0000);

    // Non-one-hot grant from the arbiter is ignored in IDLE
    cyc(4'b0011, 0, 4'b0000, 0, 0, 0, 4'b0011, 4'b0011);
    cyc(4'b0011, 0, 4'b0000, 0, 0, 0, 4'b0011, 4'b0011);
    cyc(4'b0011, 0, 4'b0001, 0, 1, 0, 4'b0011);

    waited = 0;
    while (q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    #2;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_grant_ctrl.md
# bus_grant_ctrl

Sequential bus-ownership controller wrapped around the 4-master fixed-priority arbiter. It filters raw master requests into the arbiter and registers the arbiter's combinational one-hot grant into a held bus grant. It keeps that grant while the owner keeps requesting, forces release after a hold limit, and enforces an idle turnaround before the next owner. A master that times out is locked out until it drops its request.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one master may hold GNT; legal range 2..255.
- TURNAROUND, 1: idle cycles after any release before a new grant; legal range 0..3.
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- BR  in  4  raw bus requests from masters 0..3.
- REQ_OUT  out  4  filtered requests to the arbiter: BR & ~penalty, combinational.
- BG  in  4  one-hot (or zero) grant returned combinationally by the arbiter.
- GNT  out  4  registered one-hot bus grant.
- OWNER  out  2  registered index of the current grant holder; 0 when idle.
- BUSY  out  1  registered; 1 while GNT != 0.
- TIMEOUT  out  1  registered one-cycle pulse on forced release.

## Operation
- States: IDLE, GRANT, TURN.
- IDLE, BG zero: stay in IDLE.
- IDLE, BG exactly one-hot: next edge GNT<=BG, OWNER<=encoded index, BUSY<=1, hold_cnt<=0, go to GRANT.
- IDLE, BG nonzero but not one-hot: ignore it and stay in IDLE.
- GRANT, BR[OWNER]==0: next edge GNT<=0, BUSY<=0, OWNER<=0. Go to TURN (turn_cnt<=0), or to IDLE if TURNAROUND==0.
- GRANT, BR[OWNER]==1 and hold_cnt==MAX_HOLD-1: forced release. Next edge GNT<=0, TIMEOUT<=1, penalty[OWNER]<=1, then the same transition as a normal release.
- GRANT, otherwise: hold_cnt increments. BG is ignored while in GRANT; there is no preemption.
- TURN: turn_cnt increments each cycle. When turn_cnt==TURNAROUND-1, go to IDLE at the next edge.
- penalty[i] clears at the next edge whenever BR[i]==0. Setting requires BR[i]==1, so set and clear never conflict.
- hold_cnt width is $clog2(MAX_HOLD); it never wraps, because it is reset on every grant.
- Owner release in the same cycle that hold_cnt hits the limit is a normal release: no TIMEOUT, no penalty.
- Reset, in any state including mid-grant: state IDLE, GNT=0, OWNER=0, BUSY=0, TIMEOUT=0, penalty=0, both counters 0, all effective at the next edge.

## Timing
- Grant latency: BR asserted in cycle n from IDLE gives GNT in cycle n+1. The BR->REQ_OUT->BG path is combinational within cycle n.
- Maximum GNT width: exactly MAX_HOLD cycles.
- TIMEOUT: high for exactly the first cycle GNT is 0 after a forced release.
- Release: BR drop in cycle n gives GNT=0 in n+1. The earliest next GNT is in cycle n+2+TURNAROUND.
- All outputs except REQ_OUT are registered. There are no combinational input->output paths other than REQ_OUT.

## Structure
- Shared package arb_pkg holds:
  - N_MASTERS=4
  - state encodings IDLE=2'd0, GRANT=2'd1, TURN=2'd2
  - a one-hot check function
  - a one-hot-to-index function (shared with the arbiter's encoder semantics).
- One natural sub-module: hold_timer. It is a loadable up-counter with a terminal-count flag, instantiated twice (hold and turnaround).
- The top level holds the FSM, the penalty register and the output registers. The arbiter is instantiated by the parent, not inside this block.

## Test plan
- Reset, then BR=4'b0100 held, arbiter connected: GNT=4'b0100 one cycle later with OWNER=2, BUSY=1. After BR->0: GNT=0 next cycle, then 1 TURN cycle.
- BR=4'b1001 with MAX_HOLD=16, bit 0 held: GNT=4'b0001 for exactly 16 cycles, then TIMEOUT pulses and REQ_OUT=4'b1000. Master 3 is granted 2 cycles later (TURNAROUND=1). Master 0's penalty clears once BR[0]=0.
- Owner drops BR in the same cycle hold_cnt==MAX_HOLD-1: release with TIMEOUT=0 and penalty unchanged.
- Higher-priority BR bit asserted mid-grant of master 2: GNT stays 4'b0100 until master 2 releases. The new owner appears after the turnaround.
- rst asserted during GRANT with penalty[1]=1: next cycle all outputs are 0 and REQ_OUT==BR.
- TURNAROUND=0 and back-to-back requesters: GNT gap of exactly 1 cycle (the IDLE cycle). A forced non-one-hot BG=4'b0011 in IDLE produces no grant.
